mem_stage: RTL and testbench

Dual-lane memory stage. It consumes the EX/MEM pipeline register outputs for lane 1 and lane 2, performs data-memory loads and stores through one single-port data memory, and selects the writeback result per lane. It registers the results into the MEM/WB boundary. When both lanes need memory in the same cycle, it serializes them (lane 1 first, since lane 1 is older in program order) and stalls upstream for one cycle.

---
 rtl/mem_stage_if.sv | 42 ++++
 rtl/mem_stage.sv | 113 +++++++++++
 tb/tb_mem_stage.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM/WB boundary bundle for the dual-lane memory stage.
// The slave side is the memory stage; the master side is the surrounding pipeline.
interface mem_stage_if #(
  parameter int DW = 32
);
  logic          i_RegWrite1M;
  logic          i_MemtoReg1M;
  logic          i_MemWrite1M;
  logic [DW-1:0] i_ALUResult1M;
  logic [DW-1:0] i_WriteData1M;
  logic [3:0]    i_WA1M;
  logic          i_RegWrite2M;
  logic          i_MemtoReg2M;
  logic          i_MemWrite2M;
  logic [DW-1:0] i_ALUResult2M;
  logic [DW-1:0] i_WriteData2M;
  logic [3:0]    i_WA2M;

  logic          o_StallM;
  logic          o_RegWrite1W;
  logic [DW-1:0] o_Result1W;
  logic [3:0]    o_WA1W;
  logic          o_RegWrite2W;
  logic [DW-1:0] o_Result2W;
  logic [3:0]    o_WA2W;

  modport slave (
    input  i_RegWrite1M, i_MemtoReg1M, i_MemWrite1M, i_ALUResult1M, i_WriteData1M, i_WA1M,
    input  i_RegWrite2M, i_MemtoReg2M, i_MemWrite2M, i_ALUResult2M, i_WriteData2M, i_WA2M,
    output o_StallM,
    output o_RegWrite1W, o_Result1W, o_WA1W,
    output o_RegWrite2W, o_Result2W, o_WA2W
  );

  modport master (
    output i_RegWrite1M, i_MemtoReg1M, i_MemWrite1M, i_ALUResult1M, i_WriteData1M, i_WA1M,
    output i_RegWrite2M, i_MemtoReg2M, i_MemWrite2M, i_ALUResult2M, i_WriteData2M, i_WA2M,
    input  o_StallM,
    input  o_RegWrite1W, o_Result1W, o_WA1W,
    input  o_RegWrite2W, o_Result2W, o_WA2W
  );
endinterface

// File: rtl/mem_stage.sv
// Dual-lane memory stage: one single-port data memory shared by both lanes,
// serializing lane 1 then lane 2 (with a one-cycle upstream stall) on conflict.
module mem_stage #(
  parameter int DW     = 32,
  parameter int ADDR_W = 8
) (
  input logic        clk,
  input logic        rst_n,
  mem_stage_if.slave bus
);
  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

  state_t r_state;

  logic [DW-1:0] r_mem [0:(1<<ADDR_W)-1];

  logic          r_RegWrite1W;
  logic [DW-1:0] r_Result1W;
  logic [3:0]    r_WA1W;
  logic          r_RegWrite2W;
  logic [DW-1:0] r_Result2W;
  logic [3:0]    r_WA2W;

  logic              w_acc1;
  logic              w_acc2;
  logic              w_conflict;
  logic              w_sel2;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr1;
  logic [ADDR_W-1:0] w_addr2;
  logic [ADDR_W-1:0] w_addr;
  logic [DW-1:0]     w_wdata;
  logic [DW-1:0]     w_rdata;
  logic [DW-1:0]     w_res1;
  logic [DW-1:0]     w_res2;

  assign w_acc1     = bus.i_MemtoReg1M | bus.i_MemWrite1M;
  assign w_acc2     = bus.i_MemtoReg2M | bus.i_MemWrite2M;
  assign w_conflict = w_acc1 & w_acc2;
  assign w_addr1    = bus.i_ALUResult1M[ADDR_W+1:2];
  assign w_addr2    = bus.i_ALUResult2M[ADDR_W+1:2];

  // Lane 2 owns the port in SECOND, or in IDLE when lane 1 leaves it free;
  // this also keeps lane 1 from repeating its store during SECOND.
  always_comb begin
    w_sel2  = (r_state == SECOND) || !w_acc1;
    w_addr  = w_sel2 ? w_addr2 : w_addr1;
    w_wdata = w_sel2 ? bus.i_WriteData2M : bus.i_WriteData1M;
    // Gating with rst_n drops a store whose edge arrives while reset is held.
    w_we    = rst_n & (w_sel2 ? bus.i_MemWrite2M : bus.i_MemWrite1M);
  end

  assign w_rdata = r_mem[w_addr];
  assign w_res1  = bus.i_MemtoReg1M ? w_rdata : bus.i_ALUResult1M;
  assign w_res2  = bus.i_MemtoReg2M ? w_rdata : bus.i_ALUResult2M;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_addr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_RegWrite1W <= 1'b0;
      r_Result1W   <= '0;
      r_WA1W       <= '0;
      r_RegWrite2W <= 1'b0;
      r_Result2W   <= '0;
      r_WA2W       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_RegWrite1W <= bus.i_RegWrite1M;
          r_Result1W   <= w_res1;
          r_WA1W       <= bus.i_WA1M;
          if (w_conflict) begin
            r_RegWrite2W <= 1'b0;
            r_Result2W   <= '0;
            r_WA2W       <= '0;
            r_state      <= SECOND;
          end else begin
            r_RegWrite2W <= bus.i_RegWrite2M;
            r_Result2W   <= w_res2;
            r_WA2W       <= bus.i_WA2M;
          end
        end
        SECOND: begin
          r_RegWrite1W <= 1'b0;
          r_Result1W   <= '0;
          r_WA1W       <= '0;
          r_RegWrite2W <= bus.i_RegWrite2M;
          r_Result2W   <= w_res2;
          r_WA2W       <= bus.i_WA2M;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_StallM     = rst_n & (r_state == IDLE) & w_conflict;
  assign bus.o_RegWrite1W = r_RegWrite1W;
  assign bus.o_Result1W   = r_Result1W;
  assign bus.o_WA1W       = r_WA1W;
  assign bus.o_RegWrite2W = r_RegWrite2W;
  assign bus.o_Result2W   = r_Result2W;
  assign bus.o_WA2W       = r_WA2W;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, multi-cycle
// corner sequences, and random packets against a sequential memory model.
module tb_mem_stage;
  typedef struct {
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [3:0]  wa;
  } lane_t;

  typedef struct {
    logic        rw;
    logic [31:0] res;
    logic [3:0]  wa;
  } out_t;

  typedef struct {
    lane_t l1;
    lane_t l2;
    out_t  e1;
    out_t  e2;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if #(.DW(32)) bus ();

  mem_stage #(.DW(32), .ADDR_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] m [0:255];
  vec_t vec [7];
  lane_t L0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input lane_t a, input lane_t b);
    bus.i_RegWrite1M  = a.rw;
    bus.i_MemtoReg1M  = a.mr;
    bus.i_MemWrite1M  = a.mw;
    bus.i_ALUResult1M = a.alu;
    bus.i_WriteData1M = a.wd;
    bus.i_WA1M        = a.wa;
    bus.i_RegWrite2M  = b.rw;
    bus.i_MemtoReg2M  = b.mr;
    bus.i_MemWrite2M  = b.mw;
    bus.i_ALUResult2M = b.alu;
    bus.i_WriteData2M = b.wd;
    bus.i_WA2M        = b.wa;
  endtask

  task automatic chk_w1(input string tag, input out_t e, input bit full);
    chk({tag, ".rw1"}, {31'b0, bus.o_RegWrite1W}, {31'b0, e.rw});
    if (full) begin
      chk({tag, ".res1"}, bus.o_Result1W, e.res);
      chk({tag, ".wa1"}, {28'b0, bus.o_WA1W}, {28'b0, e.wa});
    end
  endtask

  task automatic chk_w2(input string tag, input out_t e, input bit full);
    chk({tag, ".rw2"}, {31'b0, bus.o_RegWrite2W}, {31'b0, e.rw});
    if (full) begin
      chk({tag, ".res2"}, bus.o_Result2W, e.res);
      chk({tag, ".wa2"}, {28'b0, bus.o_WA2W}, {28'b0, e.wa});
    end
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    chk({tag, ".stall"}, {31'b0, bus.o_StallM}, {31'b0, exp});
  endtask

  function automatic lane_t mk(input logic rw, input logic mr, input logic mw,
                               input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] wa);
    lane_t l;
    l.rw = rw; l.mr = mr; l.mw = mw; l.alu = alu; l.wd = wd; l.wa = wa;
    return l;
  endfunction

  function automatic out_t mo(input logic rw, input logic [31:0] res, input logic [3:0] wa);
    out_t o;
    o.rw = rw; o.res = res; o.wa = wa;
    return o;
  endfunction

  // Program-order model: lane 1 fully completes before lane 2 observes memory.
  function automatic out_t model_lane(input lane_t l);
    out_t o;
    logic [7:0] a;
    a = 8'((l.alu >> 2) & 32'hFF);
    o.rw  = l.rw;
    o.wa  = l.wa;
    o.res = l.mr ? m[a] : l.alu;
    if (l.mw) m[a] = l.wd;
    return o;
  endfunction

  // Starts and ends at one time unit after a rising edge.
  task automatic run_pkt(input string tag, input lane_t a, input lane_t b);
    out_t e1, e2;
    bit conflict;
    conflict = (a.mr || a.mw) && (b.mr || b.mw);
    e1 = model_lane(a);
    e2 = model_lane(b);
    drive(a, b);
    #1;
    chk_stall(tag, conflict);
    @(posedge clk); #1;
    chk_w1(tag, e1, 1'b1);
    if (conflict) begin
      chk_w2(tag, mo(1'b0, 32'h0, 4'd0), 1'b0);
      chk_stall({tag, ".sec"}, 1'b0);
      @(posedge clk); #1;
      chk_w1({tag, ".sec"}, mo(1'b0, 32'h0, 4'd0), 1'b0);
      chk_w2({tag, ".sec"}, e2, 1'b1);
    end else begin
      chk_w2(tag, e2, 1'b1);
    end
  endtask

  function automatic lane_t rnd_lane();
    lane_t l;
    int k;
    k = $urandom_range(0, 4);
    l.rw  = 1'($urandom_range(0, 1));
    l.mr  = (k == 1 || k == 3);
    l.mw  = (k == 2 || k == 3);
    l.alu = $urandom;
    l.wd  = $urandom;
    l.wa  = 4'($urandom_range(0, 15));
    return l;
  endfunction

  initial begin
    L0 = mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    vec[0] = '{mk(1, 0, 0, 32'h15, 32'h0, 4'd3), L0, mo(1, 32'h15, 4'd3), mo(0, 32'h0, 4'd0)};
    vec[1] = '{mk(0, 0, 1, 32'h40, 32'hDEADBEEF, 4'd0), L0, mo(0, 32'h40, 4'd0), mo(0, 32'h0, 4'd0)};
    vec[2] = '{L0, mk(1, 1, 0, 32'h40, 32'h0, 4'd5), mo(0, 32'h0, 4'd0), mo(1, 32'hDEADBEEF, 4'd5)};
    vec[3] = '{mk(0, 0, 1, 32'h404, 32'hCAFE0001, 4'd0), mk(1, 0, 0, 32'h77, 32'h0, 4'd9),
               mo(0, 32'h404, 4'd0), mo(1, 32'h77, 4'd9)};
    vec[4] = '{mk(1, 1, 0, 32'h004, 32'h0, 4'd2), mk(1, 0, 0, 32'h88, 32'h0, 4'd2),
               mo(1, 32'hCAFE0001, 4'd2), mo(1, 32'h88, 4'd2)};
    vec[5] = '{mk(1, 1, 1, 32'h40, 32'h11112222, 4'd4), L0, mo(1, 32'hDEADBEEF, 4'd4), mo(0, 32'h0, 4'd0)};
    vec[6] = '{L0, mk(1, 1, 0, 32'h40, 32'h0, 4'd6), mo(0, 32'h0, 4'd0), mo(1, 32'h11112222, 4'd6)};

    drive(L0, L0);
    #12;
    chk_stall("reset", 1'b0);
    chk_w1("reset", mo(0, 32'h0, 4'd0), 1'b1);
    chk_w2("reset", mo(0, 32'h0, 4'd0), 1'b1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vec[i]) begin
      drive(vec[i].l1, vec[i].l2);
      #1;
      chk_stall($sformatf("vec%0d", i), 1'b0);
      @(posedge clk); #1;
      chk_w1($sformatf("vec%0d", i), vec[i].e1, 1'b1);
      chk_w2($sformatf("vec%0d", i), vec[i].e2, 1'b1);
    end

    // Store then dependent load in one packet: serialized, load sees new data.
    drive(mk(0, 0, 1, 32'h80, 32'h1234, 4'd0), mk(1, 1, 0, 32'h80, 32'h0, 4'd7));
    #1; chk_stall("st_ld.c0", 1'b1);
    @(posedge clk); #1;
    chk_stall("st_ld.c1", 1'b0);
    chk_w1("st_ld.c1", mo(0, 32'h0, 4'd0), 1'b0);
    chk_w2("st_ld.c1", mo(0, 32'h0, 4'd0), 1'b0);
    @(posedge clk); #1;
    chk_w1("st_ld.c2", mo(0, 32'h0, 4'd0), 1'b0);
    chk_w2("st_ld.c2", mo(1, 32'h1234, 4'd7), 1'b1);

    // Load then store to the same word: the load gets the old value.
    drive(mk(0, 0, 1, 32'h10, 32'hAA, 4'd0), L0);
    @(posedge clk); #1;
    drive(mk(1, 1, 0, 32'h10, 32'h0, 4'd1), mk(0, 0, 1, 32'h10, 32'hBB, 4'd0));
    #1; chk_stall("ld_st.c0", 1'b1);
    @(posedge clk); #1;
    chk_w1("ld_st.c1", mo(1, 32'hAA, 4'd1), 1'b1);
    @(posedge clk); #1;
    chk_w2("ld_st.c2", mo(0, 32'h0, 4'd0), 1'b0);
    drive(mk(1, 1, 0, 32'h10, 32'h0, 4'd1), L0);
    @(posedge clk); #1;
    chk_w1("ld_st.rd", mo(1, 32'hBB, 4'd1), 1'b1);

    // Reset while in SECOND: the pending lane-2 store must not land.
    drive(mk(1, 1, 0, 32'h80, 32'h0, 4'd8), mk(0, 0, 1, 32'h80, 32'h9999, 4'd0));
    @(posedge clk); #1;
    chk_w1("rst2.c1", mo(1, 32'h1234, 4'd8), 1'b1);
    rst_n = 1'b0;
    #1;
    chk_stall("rst2.asrt", 1'b0);
    chk_w1("rst2.asrt", mo(0, 32'h0, 4'd0), 1'b1);
    chk_w2("rst2.asrt", mo(0, 32'h0, 4'd0), 1'b1);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1; chk_stall("rst2.idle", 1'b1);
    drive(mk(1, 1, 0, 32'h80, 32'h0, 4'd8), L0);
    #1; chk_stall("rst2.rd", 1'b0);
    @(posedge clk); #1;
    chk_w1("rst2.rd", mo(1, 32'h1234, 4'd8), 1'b1);

    // Fill every word so the model knows all contents, then random traffic.
    for (int i = 0; i < 256; i++) begin
      run_pkt("fill", mk(0, 0, 1, ($urandom & 32'hFFFFFC03) | (32'(i) << 2), $urandom, 4'd0), L0);
    end
    for (int n = 0; n < 400; n++) begin
      lane_t a, b;
      a = rnd_lane();
      b = rnd_lane();
      if ($urandom_range(0, 2) == 0) b.alu = (a.alu & 32'h3FC) | ($urandom & 32'hFFFFFC03);
      run_pkt($sformatf("rnd%0d", n), a, b);
    end

    drive(L0, L0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
